ssp_read_streamer: RTL

- Reader-side controller for the parallel-write scratchpad (SSP).
- On a start command it issues a burst of `len` reads from the scratchpad, starting at `base_addr` and wrapping modulo the depth.
- It absorbs the scratchpad's 1-cycle registered read latency and presents the words on a valid/ready output stream.
- A 2-entry buffer guarantees no data loss under backpressure while sustaining 1 word/cycle when `out_ready` is held high.

---
 rtl/ssp_pkg.sv | 22 ++
 rtl/ssp_read_streamer_if.sv | 28 ++
 rtl/ssp_rd_fifo.sv | 51 +++++
 rtl/ssp_read_streamer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/ssp_pkg.sv
// Shared types and constants for the scratchpad read streamer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ssp_pkg;

    // Burst controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ssp_state_e;

    // Output buffer depth; the credit rule in the streamer is built around it.
    localparam int SSP_RD_BUF_DEPTH = 2;

    // Low address bits that must be zero for a read aligned to par_read words.
    function automatic int ssp_align_mask(input int par_read);
        return par_read - 1;
    endfunction

endpackage

// File: rtl/ssp_read_streamer_if.sv
// Scratchpad read port plus the outgoing valid/ready word stream.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the consumer throttles out_valid.
interface ssp_read_streamer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int PAR_READ   = 1
);
    logic                           ssp_ren;
    logic                           ssp_chip_en;
    logic [ADDR_WIDTH-1:0]          ssp_raddr;
    logic [PAR_READ*DATA_WIDTH-1:0] ssp_dout;
    logic [PAR_READ*DATA_WIDTH-1:0] out_data;
    logic                           out_valid;
    logic                           out_ready;

    // Streamer side: drives the read port and the stream.
    modport master (
        output ssp_ren, ssp_chip_en, ssp_raddr, out_data, out_valid,
        input  ssp_dout, out_ready
    );

    // Scratchpad / consumer side.
    modport slave (
        input  ssp_ren, ssp_chip_en, ssp_raddr, out_data, out_valid,
        output ssp_dout, out_ready
    );
endinterface

// File: rtl/ssp_rd_fifo.sv
// Two-entry in-order FIFO holding scratchpad words awaiting the consumer.
// Latency: a pushed word is visible at dout the cycle after the push.
// Backpressure: none internally; the caller's credit rule keeps it from overflowing.
module ssp_rd_fifo
    import ssp_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);
    localparam logic [1:0] FULL = 2'(SSP_RD_BUF_DEPTH);

    logic [WIDTH-1:0] mem [SSP_RD_BUF_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop of an empty buffer or a push into a full one without a pop is dropped.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; reset flushes everything to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SSP_RD_BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/ssp_read_streamer.sv
// Issues a burst of scratchpad reads and streams the returned words out.
// Latency: read issued in cycle t, word presented on out_valid in cycle t+2.
// Backpressure: reads are only issued while the 2-entry buffer has room for them.
module ssp_read_streamer
    import ssp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int PAR_READ   = 1,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    ssp_read_streamer_if.master   bus
);
    localparam int               WORD_W     = PAR_READ * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(ssp_align_mask(PAR_READ));

    ssp_state_e            state;
    ssp_state_e            state_nxt;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued;
    logic [LEN_WIDTH-1:0]  accepted;
    logic                  inflight;
    logic [1:0]            count;
    logic                  pop;
    logic                  ren;
    logic                  credit_ok;
    logic [WORD_W-1:0]     head_data;

    assign pop = bus.out_valid & bus.out_ready;

    // count + inflight - pop < 2, rearranged so nothing goes negative.
    assign credit_ok = (3'(count) + 3'(inflight)) < (3'd2 + 3'(pop));

    assign bus.ssp_ren     = ren;
    assign bus.ssp_chip_en = ren;
    assign bus.ssp_raddr   = ren ? (base_q + ADDR_WIDTH'(int'(issued) * PAR_READ)) : '0;
    assign bus.out_valid   = (count != 2'd0);
    assign bus.out_data    = head_data;

    // Next state, read issue and status flags.
    always_comb begin
        state_nxt = state;
        ren       = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if ((issued != len_q) && credit_ok) begin
                    ren = 1'b1;
                    if ((issued + LEN_WIDTH'(1)) == len_q) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (pop && ((accepted + LEN_WIDTH'(1)) == len_q)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register, burst parameters, progress counters and the in-flight flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            issued   <= '0;
            accepted <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= ren;
            if ((state == ST_IDLE) && start) begin
                base_q   <= base_addr & ~ALIGN_MASK;
                len_q    <= len;
                issued   <= '0;
                accepted <= '0;
            end else begin
                if (ren) begin
                    issued <= issued + LEN_WIDTH'(1);
                end
                if (pop) begin
                    accepted <= accepted + LEN_WIDTH'(1);
                end
            end
        end
    end

    // The word returned by last cycle's read is always captured; credit guarantees room.
    ssp_rd_fifo #(
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   (bus.ssp_dout),
        .pop   (pop),
        .dout  (head_data),
        .count (count)
    );

endmodule
